// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES controller poll path.
//   NES_BTN_W     width of a button byte
//   BTN_*         bit index of each button inside that byte
//   poll_state_t  state type of the poll scheduler FSM
// No ports (package).
// -----------------------------------------------------------------------------
package nes_pkg;

    localparam int NES_BTN_W = 8;

    // Bit positions in the button byte, in controller shift order.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        UPDATE  = 2'd3
    } poll_state_t;

endpackage

// File: rtl/nes_poll_timer.sv
// -----------------------------------------------------------------------------
// nes_poll_timer
// Reloadable down-counter that produces the periodic poll tick.
//   clk       in   system clock
//   rst_n_i   in   asynchronous active-low reset (counter -> PERIOD-1)
//   reload_i  in   force counter to PERIOD-1 (has priority over counting)
//   count_i   in   decrement enable
//   tick_o    out  high while counting and the counter is at 0; the counter
//                  reloads on the same edge
// -----------------------------------------------------------------------------
module nes_poll_timer #(
    parameter int unsigned PERIOD = 416_667
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic reload_i,
    input  logic count_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = count_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i || tick_o) begin
            cnt_d = RELOAD;
        end else if (count_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nes_poll_scheduler.sv
// -----------------------------------------------------------------------------
// nes_poll_scheduler
// Drives the nes_controller read handshake: issues periodic (or manual) read
// strobes, captures the returned button byte and reports press/release edges.
//   clk             in   system clock
//   i_rst_n         in   asynchronous active-low reset
//   i_enable        in   periodic polling enable (counter held at reload when 0)
//   i_poll_now      in   manual poll request, honoured only in IDLE
//   o_read_buttons  out  one-cycle read strobe (registered, high during REQUEST)
//   i_valid         in   read completion from nes_controller
//   i_buttons       in   button byte, sampled when i_valid=1 in WAIT
//   o_buttons       out  last captured button byte
//   o_pressed       out  bits that went 0->1 in the last capture
//   o_released      out  bits that went 1->0 in the last capture
//   o_event         out  one-cycle strobe: last capture changed something
//   o_busy          out  high in REQUEST or WAIT
//   o_timeout       out  one-cycle strobe when a read times out
// Build option: NES_POLL_TIMEOUT_EN adds a WAIT timeout of TIMEOUT_CYCLES;
// without it WAIT is left only on i_valid and o_timeout is tied to 0.
// -----------------------------------------------------------------------------
module nes_poll_scheduler
    import nes_pkg::*;
#(
    parameter int unsigned POLL_PERIOD    = 416_667,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_poll_now,
    output logic                 o_read_buttons,
    input  logic                 i_valid,
    input  logic [NES_BTN_W-1:0] i_buttons,
    output logic [NES_BTN_W-1:0] o_buttons,
    output logic [NES_BTN_W-1:0] o_pressed,
    output logic [NES_BTN_W-1:0] o_released,
    output logic                 o_event,
    output logic                 o_busy,
    output logic                 o_timeout
);

    poll_state_t          state_q, state_d;
    logic [NES_BTN_W-1:0] next_q, next_d;
    logic [NES_BTN_W-1:0] buttons_q, pressed_q, released_q;
    logic                 read_q, event_q, timeout_q;
    logic                 tick, start_poll, tmo_expire;
    logic                 timer_reload, timer_count;

    // Counter only runs while idle and enabled; any poll start (or disable)
    // parks it at the reload value so the next period is a full one.
    assign timer_count  = (state_q == IDLE) && i_enable;
    assign timer_reload = !i_enable || start_poll;
    // Tick and manual request in the same cycle collapse into one poll.
    assign start_poll   = (state_q == IDLE) && (tick || i_poll_now);

    nes_poll_timer #(
        .PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst_n_i  (i_rst_n),
        .reload_i (timer_reload),
        .count_i  (timer_count),
        .tick_o   (tick)
    );

`ifdef NES_POLL_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;

    // Zero on the WAIT entry cycle, counts up while waiting.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if (state_q == WAIT) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

    // A capture arriving on the expiry cycle wins over the timeout.
    assign tmo_expire = (state_q == WAIT) && !i_valid && (tmo_q == TMO_LAST);
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        unique case (state_q)
            IDLE: begin
                if (start_poll) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_valid) begin
                    state_d = UPDATE;
                    next_d  = i_buttons;
                end else if (tmo_expire) begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            next_q     <= '0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            read_q     <= 1'b0;
            event_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            // Registered strobe lines up exactly with the REQUEST cycle.
            read_q    <= (state_d == REQUEST);
            event_q   <= (state_q == UPDATE) && (next_q != buttons_q);
            timeout_q <= tmo_expire;
            if (state_q == UPDATE) begin
                buttons_q  <= next_q;
                pressed_q  <= next_q & ~buttons_q;
                released_q <= ~next_q & buttons_q;
            end
        end
    end

    assign o_read_buttons = read_q;
    assign o_buttons      = buttons_q;
    assign o_pressed      = pressed_q;
    assign o_released     = released_q;
    assign o_event        = event_q;
    assign o_busy         = (state_q == REQUEST) || (state_q == WAIT);
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
module tb_nes_poll_scheduler;

    localparam int PP = 100;
    localparam int TC = 50;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_poll_now = 1'b0;
    logic       o_read_buttons;
    logic       i_valid = 1'b0;
    logic [7:0] i_buttons = 8'h00;
    logic [7:0] o_buttons, o_pressed, o_released;
    logic       o_event, o_busy, o_timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_next = 0;          // cycle at which the next periodic strobe is due
    logic [7:0] model_btn = 8'h00;

    nes_poll_scheduler #(
        .POLL_PERIOD    (PP),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_poll_now     (i_poll_now),
        .o_read_buttons (o_read_buttons),
        .i_valid        (i_valid),
        .i_buttons      (i_buttons),
        .o_buttons      (o_buttons),
        .o_pressed      (o_pressed),
        .o_released     (o_released),
        .o_event        (o_event),
        .o_busy         (o_busy),
        .o_timeout      (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wait for a read strobe, answer it after 'delay' cycles with 'val',
    // and check the capture against the button model two cycles later.
    task automatic serve_poll(input logic [7:0] val, input int delay, input int exp_req,
                              input bit poke_now, input bit drop_en);
        int waited = 0;
        int req_cyc;
        int v_cyc;
        logic [7:0] e_p, e_r;
        logic e_ev;
        while (o_read_buttons !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (o_read_buttons !== 1'b1) begin
            errors++;
            $display("FAIL poll_wait: no read strobe within 400 cycles (got %b, need 1)", o_read_buttons);
            return;
        end
        req_cyc = cyc;
        if (exp_req >= 0) begin
            checks++;
            if (req_cyc != exp_req) begin
                errors++;
                $display("FAIL req_cycle: strobe at cycle %0d, expected %0d", req_cyc, exp_req);
            end
        end
        @(negedge clk);
        checks++;
        if (o_read_buttons !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: o_read_buttons=%b one cycle after strobe, need 0", o_read_buttons);
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait: o_busy=%b while waiting, need 1", o_busy);
        end
        if (drop_en) i_enable = 1'b0;
        i_poll_now = poke_now;
        repeat (delay - 1) @(negedge clk);
        i_poll_now = 1'b0;
        i_valid    = 1'b1;
        i_buttons  = val;
        v_cyc      = cyc;
        @(negedge clk);
        i_valid   = 1'b0;
        i_buttons = 8'($urandom);
        @(negedge clk);
        e_p  = val & ~model_btn;
        e_r  = ~val & model_btn;
        e_ev = (val != model_btn);
        checks++;
        if (o_buttons !== val) begin
            errors++;
            $display("FAIL capture_buttons: o_buttons=%h, expected %h", o_buttons, val);
        end
        checks++;
        if (o_pressed !== e_p) begin
            errors++;
            $display("FAIL capture_pressed: o_pressed=%h, expected %h", o_pressed, e_p);
        end
        checks++;
        if (o_released !== e_r) begin
            errors++;
            $display("FAIL capture_released: o_released=%h, expected %h", o_released, e_r);
        end
        checks++;
        if (o_event !== e_ev) begin
            errors++;
            $display("FAIL capture_event: o_event=%b, expected %b", o_event, e_ev);
        end
        model_btn = val;
        @(negedge clk);
        checks++;
        if (o_event !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_update: o_event=%b o_busy=%b, expected 0 0", o_event, o_busy);
        end
        exp_next = v_cyc + 2 + PP;
        $display("poll req@%0d valid@%0d val=%h buttons=%h pressed=%h released=%h",
                 req_cyc, v_cyc, val, o_buttons, o_pressed, o_released);
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_read_buttons, o_buttons, o_pressed, o_released, o_event, o_busy, o_timeout} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b btn=%h p=%h r=%h ev=%b busy=%b to=%b, expected all 0",
                     o_read_buttons, o_buttons, o_pressed, o_released, o_event, o_busy, o_timeout);
        end
        i_rst_n   = 1'b1;
        model_btn = 8'h00;
        exp_next  = cyc + PP;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_periodic_capture();
        serve_poll(8'h81, int'($urandom_range(6, 1)), exp_next, 1'b0, 1'b0);
        serve_poll(8'h01, int'($urandom_range(6, 1)), exp_next, 1'b0, 1'b0);
        serve_poll(8'h01, int'($urandom_range(6, 1)), exp_next, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            serve_poll(8'($urandom), int'($urandom_range(8, 1)), exp_next, 1'b0, 1'b0);
        end
    endtask

    task automatic test_poll_now();
        int pulses = 0;
        int k;
        i_enable = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (o_read_buttons === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL disabled_idle: %0d strobes while disabled, expected 0", pulses);
        end
        i_poll_now = 1'b1;
        k = cyc;
        @(negedge clk);
        i_poll_now = 1'b0;
        serve_poll(8'($urandom), int'($urandom_range(6, 2)), k + 1, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_read_buttons === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL poll_now_busy: %0d extra strobes, expected 0", pulses);
        end
        // Re-enable: a full period from the held reload value, then drop
        // enable mid-poll; the poll must still complete.
        i_enable = 1'b1;
        k = cyc;
        serve_poll(8'($urandom), int'($urandom_range(6, 2)), k + PP, 1'b0, 1'b1);
    endtask

    task automatic test_ignored_valid();
        i_enable  = 1'b0;
        i_valid   = 1'b1;
        i_buttons = ~model_btn;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_buttons !== model_btn || o_event !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: btn=%h ev=%b busy=%b, expected btn=%h ev=0 busy=0",
                     o_buttons, o_event, o_busy, model_btn);
        end
        $display("idle i_valid ignored, buttons=%h", o_buttons);
    endtask

`ifdef NES_POLL_TIMEOUT_EN
    task automatic test_timeout();
        int r, first, cnt;
        logic [7:0] v;
        i_enable   = 1'b0;
        i_poll_now = 1'b1;
        @(negedge clk);
        i_poll_now = 1'b0;
        r = cyc;
        first = -1;
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (o_timeout === 1'b1) begin
                cnt++;
                if (first < 0) first = cyc;
            end
        end
        checks++;
        if (cnt != 1 || first != r + 1 + TC) begin
            errors++;
            $display("FAIL timeout_pulse: %0d pulses first@%0d, expected 1 at %0d", cnt, first, r + 1 + TC);
        end
        checks++;
        if (o_buttons !== model_btn || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: btn=%h busy=%b, expected %h 0", o_buttons, o_busy, model_btn);
        end
        $display("timeout strobe at cycle %0d (request %0d)", first, r);
        i_poll_now = 1'b1;
        r = cyc;
        @(negedge clk);
        i_poll_now = 1'b0;
        serve_poll(8'($urandom), 3, r + 1, 1'b0, 1'b0);
        // Capture on the expiry cycle wins.
        i_poll_now = 1'b1;
        @(negedge clk);
        i_poll_now = 1'b0;
        r = cyc;
        repeat (TC) @(negedge clk);
        v = ~model_btn;
        i_valid   = 1'b1;
        i_buttons = v;
        @(negedge clk);
        i_valid = 1'b0;
        cnt = (o_timeout === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (o_timeout === 1'b1) cnt++;
        checks++;
        if (o_buttons !== v || cnt != 0) begin
            errors++;
            $display("FAIL expiry_capture: btn=%h timeouts=%0d, expected btn=%h timeouts=0", o_buttons, cnt, v);
        end
        model_btn = v;
        $display("capture on expiry cycle %0d buttons=%h", r + TC, o_buttons);
    endtask
`else
    task automatic test_no_timeout();
        int cnt = 0;
        logic [7:0] v;
        i_enable   = 1'b0;
        i_poll_now = 1'b1;
        @(negedge clk);
        i_poll_now = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (o_timeout === 1'b1) cnt++;
        end
        checks++;
        if (o_busy !== 1'b1 || cnt != 0) begin
            errors++;
            $display("FAIL no_timeout: busy=%b timeouts=%0d, expected busy=1 timeouts=0", o_busy, cnt);
        end
        v = ~model_btn;
        i_valid   = 1'b1;
        i_buttons = v;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_buttons !== v || o_event !== 1'b1) begin
            errors++;
            $display("FAIL late_capture: btn=%h ev=%b, expected %h 1", o_buttons, o_event, v);
        end
        model_btn = v;
        $display("long wait completed, buttons=%h", o_buttons);
    endtask
`endif

    task automatic test_reset_mid_poll();
        int r;
        i_enable   = 1'b0;
        i_poll_now = 1'b1;
        @(negedge clk);
        i_poll_now = 1'b0;
        checks++;
        if (o_read_buttons !== 1'b1) begin
            errors++;
            $display("FAIL prereset_strobe: o_read_buttons=%b, expected 1", o_read_buttons);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_read_buttons !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_request: rd=%b busy=%b, expected 0 0", o_read_buttons, o_busy);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        model_btn = 8'h00;
        @(negedge clk);
        i_poll_now = 1'b1;
        @(negedge clk);
        i_poll_now = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_read_buttons, o_buttons, o_pressed, o_released, o_event, o_busy, o_timeout} !== 28'h0) begin
            errors++;
            $display("FAIL reset_wait: rd=%b btn=%h p=%h r=%h ev=%b busy=%b to=%b, expected all 0",
                     o_read_buttons, o_buttons, o_pressed, o_released, o_event, o_busy, o_timeout);
        end
        @(negedge clk);
        i_rst_n   = 1'b1;
        @(negedge clk);
        i_valid   = 1'b1;
        i_buttons = 8'h5A;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_buttons !== 8'h00 || o_busy !== 1'b0 || o_event !== 1'b0) begin
            errors++;
            $display("FAIL stale_valid: btn=%h busy=%b ev=%b, expected 00 0 0", o_buttons, o_busy, o_event);
        end
        $display("reset during wait cleared outputs, stale i_valid ignored");
        i_poll_now = 1'b1;
        r = cyc;
        @(negedge clk);
        i_poll_now = 1'b0;
        serve_poll(8'($urandom_range(255, 1)), int'($urandom_range(5, 1)), r + 1, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_periodic_capture();
        test_poll_now();
        test_ignored_valid();
`ifdef NES_POLL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_poll();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
